pwm_duty_decoder: RTL

Measures the PWM waveform from the PWM generator stage (50 MHz system clock, 16 duty steps × 16 clock cycles = 256-cycle period) and recovers the 4-bit duty cycle that produced it. It sits directly downstream of the PWM generator. It closes the loop for self-check and status reporting by producing a registered duty value, a per-period valid strobe, and fault flags for period and timeout errors.

---
 rtl/pwm_dec_pkg.sv | 27 ++
 rtl/pwm_dec_sync.sv | 70 +++++++
 rtl/pwm_duty_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pwm_dec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_dec_pkg                                                       |
// | Shared types and constants for the PWM duty decoder.                       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package pwm_dec_pkg;

  localparam int c_cnt_w            = 10;
  localparam int c_cycles_per_step  = 16;
  localparam int c_steps            = 16;
  localparam int c_nominal_period   = c_steps * c_cycles_per_step;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_dec_state_e;

  // Counters park at the limit instead of wrapping.
  function automatic logic [c_cnt_w-1:0] sat_inc(input logic [c_cnt_w-1:0] val,
                                                 input logic [c_cnt_w-1:0] lim);
    return (val >= lim) ? lim : val + c_cnt_w'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_dec_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_dec_sync                                                      |
// | 2-flop synchroniser, optional 3-tap majority filter (macro                 |
// | PWM_DEC_GLITCH_FILTER_EN) and rise/fall edge detector for pwm_in.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pwm_dec_sync
  import pwm_dec_pkg::*;
(
  input  logic clk_50M,
  input  logic reset_n,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_lvl;

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= pwm_in;
      r_sync <= r_meta;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic r_d1;
  logic r_d2;
  logic r_filt;

  // Registered majority vote: single-cycle pulses and notches never win.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_d1   <= 1'b0;
      r_d2   <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_d1   <= r_sync;
      r_d2   <= r_d1;
      r_filt <= (r_sync & r_d1) | (r_sync & r_d2) | (r_d1 & r_d2);
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_sync;
`endif

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_lvl;
    end
  end

  assign level = w_lvl;
  assign rise  = w_lvl & ~r_prev;
  assign fall  = ~w_lvl & r_prev;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : pwm_duty_decoder                                                  |
// | Recovers the 4-bit duty of a 256-cycle PWM waveform, flags bad periods     |
// | and stuck lines. Optional macro: PWM_DEC_GLITCH_FILTER_EN.                 |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module pwm_duty_decoder
  import pwm_dec_pkg::*;
#(
  parameter int CYCLES_PER_STEP = c_cycles_per_step,
  parameter int STEPS           = c_steps,
  parameter int PERIOD_TOL      = 8,
  parameter int TIMEOUT         = 2 * c_nominal_period
) (
  input  logic       clk_50M,
  input  logic       reset_n,
  input  logic       pwm_in,
  output logic [3:0] duty_out,
  output logic       duty_valid,
  output logic       period_err,
  output logic       timeout
);

  localparam int                 c_per_nom   = STEPS * CYCLES_PER_STEP;
  localparam logic [c_cnt_w-1:0] c_timeout   = c_cnt_w'(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_per_lo    = c_cnt_w'(c_per_nom - PERIOD_TOL);
  localparam logic [c_cnt_w-1:0] c_per_hi    = c_cnt_w'(c_per_nom + PERIOD_TOL);
  localparam logic [c_cnt_w-1:0] c_half_step = c_cnt_w'(CYCLES_PER_STEP / 2);
  localparam logic [c_cnt_w-1:0] c_step      = c_cnt_w'(CYCLES_PER_STEP);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_duty_max  = c_cnt_w'(15);

  logic w_level;
  logic w_rise;
  logic w_fall;

  pwm_dec_sync u_sync (
    .clk_50M (clk_50M),
    .reset_n (reset_n),
    .pwm_in  (pwm_in),
    .level   (w_level),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  pwm_dec_state_e     r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_high_cnt, w_high_nxt;
  logic [c_cnt_w-1:0] r_per_cnt, w_per_nxt;
  logic [3:0]         r_duty, w_duty_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_perr, w_perr_nxt;
  logic               r_tmo, w_tmo_nxt;

  logic [c_cnt_w-1:0] w_per_inc;
  logic [c_cnt_w-1:0] w_high_inc;
  logic [c_cnt_w-1:0] w_duty_q;
  logic [3:0]         w_duty_calc;
  logic               w_tmo_hit;
  logic               w_in_tol;

  assign w_per_inc   = sat_inc(r_per_cnt, c_timeout);
  assign w_high_inc  = sat_inc(r_high_cnt, c_timeout);
  // Timeout outranks a coincident rise, so it is decoded ahead of the state.
  assign w_tmo_hit   = (w_per_inc >= c_timeout);
  assign w_in_tol    = (r_per_cnt >= c_per_lo) && (r_per_cnt <= c_per_hi);
  assign w_duty_q    = (r_high_cnt + c_half_step) / c_step;
  assign w_duty_calc = (w_duty_q > c_duty_max) ? 4'd15 : w_duty_q[3:0];

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= SYNC;
      r_high_cnt <= '0;
      r_per_cnt  <= '0;
      r_duty     <= 4'd0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_high_cnt <= w_high_nxt;
      r_per_cnt  <= w_per_nxt;
      r_duty     <= w_duty_nxt;
      r_valid    <= w_valid_nxt;
      r_perr     <= w_perr_nxt;
      r_tmo      <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_tmo_hit) begin
      w_state_nxt = SYNC;
    end else begin
      case (r_state)
        SYNC:    if (w_rise) w_state_nxt = HIGH;
        HIGH:    if (w_fall) w_state_nxt = LOW;
        LOW:     if (w_rise) w_state_nxt = HIGH;
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_comb begin
    w_high_nxt  = r_high_cnt;
    w_per_nxt   = w_per_inc;
    w_duty_nxt  = r_duty;
    w_valid_nxt = 1'b0;
    w_perr_nxt  = r_perr;
    w_tmo_nxt   = r_tmo;
    if (w_tmo_hit) begin
      w_high_nxt  = '0;
      w_per_nxt   = '0;
      w_valid_nxt = 1'b1;
      w_tmo_nxt   = 1'b1;
      w_duty_nxt  = w_level ? 4'd15 : 4'd0;
    end else begin
      case (r_state)
        SYNC: begin
          if (w_rise) begin
            w_high_nxt = c_one;
            w_per_nxt  = c_one;
          end
        end
        HIGH: begin
          if (!w_fall) w_high_nxt = w_high_inc;
        end
        LOW: begin
          // The closing rise is the first cycle of the next period.
          if (w_rise) begin
            w_valid_nxt = 1'b1;
            w_high_nxt  = c_one;
            w_per_nxt   = c_one;
            if (w_in_tol) begin
              w_duty_nxt = w_duty_calc;
              w_perr_nxt = 1'b0;
              w_tmo_nxt  = 1'b0;
            end else begin
              w_perr_nxt = 1'b1;
            end
          end
        end
        default: begin
          w_high_nxt = '0;
          w_per_nxt  = '0;
        end
      endcase
    end
  end

  assign duty_out   = r_duty;
  assign duty_valid = r_valid;
  assign period_err = r_perr;
  assign timeout    = r_tmo;

endmodule
`default_nettype wire
